// File: rtl/fetch_controller.sv
// fetch_controller
//   Walks the external 16-bit program counter through variable-length
//   instructions (1-3 bytes) held in byte-wide instruction memory. Each byte
//   is read with a req/ack handshake. The opcode and its operands are
//   assembled and then offered to the decoder through valid/ready. A jump from
//   execute reloads the PC and discards any partly fetched instruction.
//
// Ports
//   clock, reset        posedge clock, synchronous active-low reset
//   halt                blocks the start of a new opcode fetch
//   pc_count            current PC value from the external counter
//   pc_increment        one-cycle pulse: PC += 1 (one per acked byte)
//   pc_set              one-cycle pulse: PC <= pc_new_count
//   pc_new_count        jump target, zero when pc_set is low
//   mem_req, mem_addr   byte read request and its address (pc_count)
//   mem_ack, mem_rdata  read data valid this cycle, and the data byte
//   jump_valid          redirect request, jump_target holds its address
//   insn_valid          assembled instruction available
//   insn_ready          decoder accepts when valid & ready
//   insn_opcode         opcode byte
//   insn_operand        {byte2, byte1}; bytes not used are zero
//   insn_length         1, 2 or 3
//   insn_pc             address of the opcode byte
module fetch_controller #(
   parameter int unsigned ADDR_WIDTH = 16,
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    halt,
   input  logic [ADDR_WIDTH-1:0]   pc_count,
   output logic                    pc_increment,
   output logic                    pc_set,
   output logic [ADDR_WIDTH-1:0]   pc_new_count,
   output logic                    mem_req,
   output logic [ADDR_WIDTH-1:0]   mem_addr,
   input  logic                    mem_ack,
   input  logic [DATA_WIDTH-1:0]   mem_rdata,
   input  logic                    jump_valid,
   input  logic [ADDR_WIDTH-1:0]   jump_target,
   output logic                    insn_valid,
   input  logic                    insn_ready,
   output logic [DATA_WIDTH-1:0]   insn_opcode,
   output logic [2*DATA_WIDTH-1:0] insn_operand,
   output logic [1:0]              insn_length,
   output logic [ADDR_WIDTH-1:0]   insn_pc
);

   typedef enum logic [1:0] {StFetchOp, StFetchB1, StFetchB2, StIssue} state_e;

   state_e                  r_state;
   state_e                  w_state_next;
   logic                    w_jump;
   logic [1:0]              w_op_length;
   logic [DATA_WIDTH-1:0]   r_opcode;
   logic [2*DATA_WIDTH-1:0] r_operand;
   logic [1:0]              r_length;
   logic [ADDR_WIDTH-1:0]   r_pc;

   // Reset masks the jump so the PC is not disturbed while held in reset.
   assign w_jump = reset & jump_valid;

   // Length from the two top opcode bits: 00 -> 1, 01 -> 2, 1x -> 3.
   assign w_op_length = mem_rdata[DATA_WIDTH-1] ? 2'd3 :
                        (mem_rdata[DATA_WIDTH-2] ? 2'd2 : 2'd1);

   // State register.
   always_ff @(posedge clock) begin
      if (!reset) begin
         r_state <= StFetchOp;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic. pc_increment already means "byte accepted, no jump".
   always_comb begin
      w_state_next = r_state;
      if (jump_valid) begin
         w_state_next = StFetchOp;
      end else begin
         case (r_state)
            StFetchOp: begin
               if (pc_increment) begin
                  w_state_next = (w_op_length == 2'd1) ? StIssue : StFetchB1;
               end
            end
            StFetchB1: begin
               if (pc_increment) begin
                  w_state_next = (r_length == 2'd2) ? StIssue : StFetchB2;
               end
            end
            StFetchB2: begin
               if (pc_increment) begin
                  w_state_next = StIssue;
               end
            end
            StIssue: begin
               if (insn_ready) begin
                  w_state_next = StFetchOp;
               end
            end
            default: w_state_next = StFetchOp;
         endcase
      end
   end

   // Output logic. A jump abandons the outstanding request, so the ack that
   // may arrive with it is ignored and the PC is not advanced.
   always_comb begin
      mem_req    = 1'b0;
      insn_valid = 1'b0;
      case (r_state)
         StFetchOp:            mem_req    = !halt;
         StFetchB1, StFetchB2: mem_req    = 1'b1;
         StIssue:              insn_valid = 1'b1;
         default:              mem_req    = 1'b0;
      endcase
      if (!reset || jump_valid) begin
         mem_req = 1'b0;
      end
      mem_addr     = mem_req ? pc_count : '0;
      pc_increment = mem_req & mem_ack;
      pc_set       = w_jump;
      pc_new_count = w_jump ? jump_target : '0;
   end

   // Instruction assembly registers.
   always_ff @(posedge clock) begin
      if (!reset) begin
         r_opcode  <= '0;
         r_operand <= '0;
         r_length  <= 2'd0;
         r_pc      <= '0;
      end else if (pc_increment) begin
         case (r_state)
            StFetchOp: begin
               r_opcode  <= mem_rdata;
               r_operand <= '0;
               r_length  <= w_op_length;
               r_pc      <= pc_count;
            end
            StFetchB1: r_operand[DATA_WIDTH-1:0]            <= mem_rdata;
            StFetchB2: r_operand[2*DATA_WIDTH-1:DATA_WIDTH] <= mem_rdata;
            default:   r_opcode                             <= r_opcode;
         endcase
      end
   end

   assign insn_opcode  = r_opcode;
   assign insn_operand = r_operand;
   assign insn_length  = r_length;
   assign insn_pc      = r_pc;

endmodule
